// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register with next-PC selection and a return-address stack.
// The next PC is one of: hold, sequential step, relative branch, absolute jump,
// call (push return address) or return (pop). The return-address stack is a
// circular buffer. When it is full, a push overwrites the oldest entry. Overflow
// and underflow raise a sticky error flag that only reset clears.
module pc_sequencer #(
    parameter int PC_W      = 7,
    parameter int STEP      = 1,
    parameter int OFF_W     = 5,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [OFF_W-1:0] br_off,
    input  logic             jmp,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  jmp_tgt,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [PC_W-1:0]  STEP_V  = PC_W'(STEP);
    localparam logic [PC_W-1:0]  RESET_V = PC_W'(RESET_PC);
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Source of the next PC, already resolved by priority.
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_CALL,
        SRC_RET
    } pc_src_t;

    pc_src_t                src;
    logic [PC_W-1:0]        pc_next;
    logic [PC_W-1:0]        off_ext;
    logic [PC_W-1:0]        br_tgt;
    logic signed [OFF_W-1:0] off_s;

    logic [PC_W-1:0]        ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]       top;
    logic [PTR_W-1:0]       top_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   push;
    logic                   pop;
    logic                   err_set;

    // Sequential successor. It depends only on the PC register, and adds wrap modulo 2^PC_W.
    assign pc_plus = pc + STEP_V;

    // Branch target. A signed size cast sign-extends a short offset and truncates a wide one.
    assign off_s   = $signed(br_off);
    assign off_ext = PC_W'(off_s);
    assign br_tgt  = pc + off_ext;

    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == DEPTH_V);

    // Priority resolution of the control inputs. Reset is handled in the register block.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        src = SRC_SEQ;
        if (stall) begin
            src = SRC_HOLD;
        end else if (ret) begin
            src = SRC_RET;
        end else if (call) begin
            src = SRC_CALL;
        end else if (jmp) begin
            src = SRC_JUMP;
        end else if (br_taken) begin
            src = SRC_BRANCH;
        end
    end

    // Next-PC selection and RAS push/pop/error requests for the chosen source.
    always_comb begin
        pc_next = pc_plus;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        unique case (src)
            SRC_HOLD:   pc_next = pc;
            SRC_BRANCH: pc_next = br_tgt;
            SRC_JUMP:   pc_next = jmp_tgt;
            SRC_CALL: begin
                pc_next = jmp_tgt;
                push    = 1'b1;
                err_set = ras_full;
            end
            SRC_RET: begin
                if (!ras_empty) begin
                    pc_next = ras_mem[top];
                    pop     = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            default:    pc_next = pc_plus;
        endcase
    end

    // Next top pointer and count. The count saturates at RAS_DEPTH while the pointer keeps wrapping.
    always_comb begin
        top_next = top;
        cnt_next = cnt;
        if (push) begin
            top_next = top + PTR_ONE;
            if (!ras_full) begin
                cnt_next = cnt + CNT_ONE;
            end
        end else if (pop) begin
            top_next = top - PTR_ONE;
            cnt_next = cnt - CNT_ONE;
        end
    end

    // PC, RAS bookkeeping and the sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            pc      <= RESET_V;
            top     <= '1;
            cnt     <= '0;
            ras_err <= 1'b0;
        end else begin
            pc  <= pc_next;
            top <= top_next;
            cnt <= cnt_next;
            if (err_set) begin
                ras_err <= 1'b1;
            end
        end
    end

    // RAS storage. A push writes the new top slot. When the stack is full, that slot holds the oldest entry.
    always_ff @(posedge clk) begin
        // NOTE: the stack array is not reset; a zero count makes every slot dead, so clearing it buys nothing.
        if (!rst && push) begin
            ras_mem[top_next] <= pc_plus;
        end
    end

endmodule
